// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage req/ack data-memory access with pipeline stall, timeout abort
// and MEM/WB register. Define MEM_ALIGN_CHECK_EN to reject word-misaligned accesses with err_o.
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   ST_IDLE | no transaction outstanding; a pending access stalls and issues
//   ST_BUSY | mem_req_o held, waiting for mem_ack_i or the timeout abort
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        WB_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALUout_i,
    input  logic [DATA_W-1:0] MemWriteData_i,
    input  logic [5:0]        RegWriteAddr_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o,
    output logic [1:0]        WB_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [DATA_W-1:0] ALUout_o,
    output logic [5:0]        RegWriteAddr_o
);

    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [1:0]          wb_q, wb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [5:0]          rd_q, rd_d;

    logic                access;
    logic                misalign;
    logic                timeout_hit;
    logic                stall_c;
    logic                abort_c;
    logic                rd_ack_c;

    assign access = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = access & (ALUout_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Last BUSY cycle allowed; an ack arriving in this same cycle still wins.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;
        stall_c  = 1'b0;
        abort_c  = 1'b0;
        rd_ack_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misalign) begin
                        err_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = MemWrite_i;
                        addr_d  = {ALUout_i[DATA_W-1:2], 2'b00};
                        wdata_d = MemWriteData_i;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    rd_ack_c = ~we_q;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    abort_c = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // MEM/WB: bubble while stalled; a dropped access (abort or misalign) retires with WB cleared.
    always_comb begin
        wb_d    = wb_q;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        if (stall_c) begin
            wb_d = 2'b00;
        end else begin
            wb_d  = err_d ? 2'b00 : WB_i;
            alu_d = ALUout_i;
            rd_d  = RegWriteAddr_i;
            if (abort_c) begin
                rdata_d = '0;
            end else if (rd_ack_c) begin
                rdata_d = mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wb_q    <= 2'b00;
            rdata_q <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
        end
    end

    // The stall is combinational, so reset must mask it while EX/MEM may still present an access.
    assign stall_o        = stall_c & ~rst_i;
    assign mem_req_o      = req_q;
    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign err_o          = err_q;
    assign WB_o           = wb_q;
    assign ReadData_o     = rdata_q;
    assign ALUout_o       = alu_q;
    assign RegWriteAddr_o = rd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: the driver predicts MEM/WB retirements and
// memory requests; a monitor and a memory responder pop and compare them independently.
module tb_mem_access_unit;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int NO_ACK  = 255;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        WB_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic [DATA_W-1:0] ALUout_i;
    logic [DATA_W-1:0] MemWriteData_i;
    logic [5:0]        RegWriteAddr_i;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic              stall_o;
    logic              err_o;
    logic [1:0]        WB_o;
    logic [DATA_W-1:0] ReadData_o;
    logic [DATA_W-1:0] ALUout_o;
    logic [5:0]        RegWriteAddr_o;

    mem_access_unit #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .WB_i           (WB_i),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .ALUout_i       (ALUout_i),
        .MemWriteData_i (MemWriteData_i),
        .RegWriteAddr_i (RegWriteAddr_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ack_i      (mem_ack_i),
        .stall_o        (stall_o),
        .err_o          (err_o),
        .WB_o           (WB_o),
        .ReadData_o     (ReadData_o),
        .ALUout_o       (ALUout_o),
        .RegWriteAddr_o (RegWriteAddr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [5:0]  rd;
        logic [31:0] rdata;
        logic        err;
        int          stall;
    } ret_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } memx_t;

    ret_t        ret_q[$];
    memx_t       mem_q[$];
    logic [31:0] model_rdata = '0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one EX/MEM instruction, predict its outcome, and hold it until the stage advances.
    task automatic issue(input bit rd, input bit wr, input logic [1:0] wb, input logic [31:0] alu,
                         input logic [31:0] wdata, input logic [5:0] rdst, input int lat,
                         input logic [31:0] rdat);
        bit    acc;
        bit    mis;
        bit    to;
        bit    s;
        int    n;
        ret_t  r;
        memx_t m;
        acc = rd | wr;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = acc && (alu[1:0] != 2'b00);
`endif
        to = acc && !mis && (lat >= TIMEOUT);
        if (acc && !mis) begin
            m.we    = wr;
            m.addr  = {alu[31:2], 2'b00};
            m.wdata = wdata;
            m.lat   = lat;
            m.rdata = rdat;
            mem_q.push_back(m);
        end
        if (to) model_rdata = '0;
        else if (acc && !mis && !wr) model_rdata = rdat;
        r.wb    = (to || mis) ? 2'b00 : wb;
        r.alu   = alu;
        r.rd    = rdst;
        r.rdata = model_rdata;
        r.err   = to || mis;
        r.stall = (!acc || mis) ? 0 : (to ? TIMEOUT : 1 + lat);
        ret_q.push_back(r);

        MemRead_i      = rd;
        MemWrite_i     = wr;
        WB_i           = wb;
        ALUout_i       = alu;
        MemWriteData_i = wdata;
        RegWriteAddr_i = rdst;
        mon_en         = 1'b1;

        n = 0;
        forever begin
            @(negedge clk_i);
            s = stall_o;
            @(posedge clk_i);
            #1;
            n++;
            if (!s) break;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL retire_wait: stall_o still 1 after %0d cycles, required release", n);
                break;
            end
        end
    endtask

    // Memory responder: checks each request against the predicted access and acks on schedule.
    initial begin
        memx_t cur;
        bit    in_txn;
        int    busy_k;
        in_txn      = 1'b0;
        busy_k      = 0;
        cur.lat     = NO_ACK;
        cur.we      = 1'b0;
        cur.addr    = '0;
        cur.wdata   = '0;
        cur.rdata   = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_req_o) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    busy_k = 0;
                    if (mem_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL req_unexpected: got request addr=0x%0h, required none", mem_addr_o);
                        cur.lat = NO_ACK;
                    end else begin
                        cur = mem_q.pop_front();
                        check("req_we", 64'(mem_we_o), 64'(cur.we));
                        check("req_addr", 64'(mem_addr_o), 64'(cur.addr));
                        if (cur.we) check("req_wdata", 64'(mem_wdata_o), 64'(cur.wdata));
                    end
                end else begin
                    check("req_addr_stable", 64'(mem_addr_o), 64'(cur.addr));
                end
                if (busy_k == cur.lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = cur.we ? $urandom : cur.rdata;
                end else begin
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = $urandom;
                end
                busy_k++;
            end else begin
                in_txn      = 1'b0;
                mem_ack_i   = ($urandom_range(0, 5) == 0);
                mem_rdata_i = $urandom;
            end
        end
    end

    // Monitor: after every non-stalled edge the MEM/WB register must hold the next retirement.
    bit   prev_stall = 1'b1;
    bit   armed = 1'b0;
    int   stall_run = 0;
    ret_t er;
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (armed && !prev_stall) begin
                if (ret_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL retire_unexpected: got retirement, required none");
                end else begin
                    er = ret_q.pop_front();
                    check("ret_wb", 64'(WB_o), 64'(er.wb));
                    check("ret_alu", 64'(ALUout_o), 64'(er.alu));
                    check("ret_rd", 64'(RegWriteAddr_o), 64'(er.rd));
                    check("ret_rdata", 64'(ReadData_o), 64'(er.rdata));
                    check("ret_err", 64'(err_o), 64'(er.err));
                    check("ret_stall_cycles", 64'(stall_run), 64'(er.stall));
                end
                stall_run = 0;
            end else if (armed) begin
                check("bubble_wb", 64'(WB_o), 64'd0);
                check("bubble_err", 64'(err_o), 64'd0);
            end
            if (stall_o) stall_run++;
            prev_stall = stall_o;
            armed      = 1'b1;
        end else begin
            armed     = 1'b0;
            stall_run = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          kind;
        logic [31:0] a;
        int          n;
        rst_i          = 1'b1;
        WB_i           = 2'b00;
        MemRead_i      = 1'b0;
        MemWrite_i     = 1'b0;
        ALUout_i       = '0;
        MemWriteData_i = '0;
        RegWriteAddr_i = '0;
        #2;
        check("rst_req", 64'(mem_req_o), 64'd0);
        check("rst_we", 64'(mem_we_o), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_wdata", 64'(mem_wdata_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_wb", 64'(WB_o), 64'd0);
        check("rst_rdata", 64'(ReadData_o), 64'd0);
        check("rst_alu", 64'(ALUout_o), 64'd0);
        check("rst_rd", 64'(RegWriteAddr_o), 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        issue(1'b0, 1'b0, 2'b01, 32'd7, 32'h0, 6'd3, 0, 32'h0);
        issue(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 6'd10, 3, 32'h1234_5678);
        issue(1'b0, 1'b1, 2'b00, 32'h80, 32'hCAFE_F00D, 6'd0, 0, 32'h0);
        issue(1'b1, 1'b1, 2'b01, 32'hC4, 32'h5555_AAAA, 6'd4, 1, 32'hFFFF_0000);
        issue(1'b1, 1'b0, 2'b11, 32'h100, 32'h0, 6'd12, NO_ACK, 32'h0);
        issue(1'b1, 1'b0, 2'b11, 32'h104, 32'h0, 6'd13, 0, 32'h0BAD_F00D);
        issue(1'b1, 1'b0, 2'b11, 32'h41, 32'h0, 6'd14, 2, 32'h7777_1111);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 7);
            lat  = ($urandom_range(0, 11) == 0) ? NO_ACK : $urandom_range(0, 4);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            issue(kind == 3 || kind == 4 || kind == 6, kind == 5 || kind == 6,
                  2'($urandom), a, $urandom, 6'($urandom), lat, $urandom);
        end

        issue(1'b0, 1'b0, 2'b11, 32'hDEAD_BEEF, 32'h0, 6'd9, 0, 32'h0);
        @(negedge clk_i);
        #1;
        mon_en = 1'b0;

        // Reset while a load is outstanding and EX/MEM still presents it.
        begin
            memx_t m;
            m.we    = 1'b0;
            m.addr  = 32'h200;
            m.wdata = 32'h0;
            m.lat   = NO_ACK;
            m.rdata = 32'h0;
            mem_q.push_back(m);
        end
        @(posedge clk_i);
        #1;
        MemRead_i      = 1'b1;
        MemWrite_i     = 1'b0;
        WB_i           = 2'b11;
        ALUout_i       = 32'h200;
        RegWriteAddr_i = 6'd5;
        n = 0;
        while (!mem_req_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("midbusy_req_seen", 64'(mem_req_o), 64'd1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_req", 64'(mem_req_o), 64'd0);
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_err", 64'(err_o), 64'd0);
        check("midrst_wb", 64'(WB_o), 64'd0);
        check("midrst_alu", 64'(ALUout_o), 64'd0);
        check("midrst_rd", 64'(RegWriteAddr_o), 64'd0);
        check("midrst_rdata", 64'(ReadData_o), 64'd0);
        MemRead_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("post_rst_req", 64'(mem_req_o), 64'd0);
        check("post_rst_err", 64'(err_o), 64'd0);
        check("ret_queue_empty", 64'(ret_q.size()), 64'd0);
        check("mem_queue_empty", 64'(mem_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
